safe_sync_obi_responder: RTL

OBI responder that gives the harts of the safe CPU subsystem a hardware barrier and sync-status registers. It sits on the data side of the OBI interconnect, one responder port per hart, and answers the harts' data requests directly. A hart that reads the BARRIER register is held without `rvalid` until every participating hart has arrived. All waiting harts are then released in the same cycle.

---
 rtl/safe_sync_obi_responder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/safe_sync_obi_responder.sv
// safe_sync_obi_responder: OBI responder giving each hart a hardware
// barrier plus sync-status and participation-mask registers.
// Register map (addr[3:2]): 0x0 BARRIER, 0x4 STATUS, 0x8 MASK, 0xC reserved.
// Optional barrier timeout: define SAFE_SYNC_TIMEOUT_EN.

package safe_sync_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module safe_sync_obi_responder
    import safe_sync_obi_pkg::*;
#(
    parameter int          NHARTS         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  obi_req_t  [NHARTS-1:0] core_req_i,
    output obi_resp_t [NHARTS-1:0] core_resp_o,
    output logic                   sync_done_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e            state_q [NHARTS];
    state_e            state_d [NHARTS];
    logic [31:0]       rdata_q [NHARTS];
    logic [31:0]       rdata_d [NHARTS];
    logic [NHARTS-1:0] arrived_q, arrived_d;
    logic [NHARTS-1:0] mask_q, mask_d;
    logic [7:0]        gen_q, gen_d;
    logic              timeout_q, timeout_d;

    logic [NHARTS-1:0] gnt_s;
    logic              release_s;
    logic              fire_s;
    logic [7:0]        arrived_ext_s;
    logic [31:0]       mask_ext_s;
    logic              unused_req_s;

    // Barrier completes when every participating hart has arrived; only
    // registered state is used so the release is glitch-free in its cycle.
    assign release_s   = (mask_q != '0) && ((arrived_q & mask_q) == mask_q);
    assign sync_done_o = release_s;
    assign timeout_o   = timeout_q;

`ifdef SAFE_SYNC_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Timeout counter: runs while someone is waiting and no release happens.
    always_comb begin
        if (release_s || fire_s) begin
            tmo_cnt_d = 16'd0;
        end else if (arrived_q != '0) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_d = 16'd0;
        end
    end

    assign fire_s = (arrived_q != '0) && !release_s && (tmo_cnt_q == TMO_LAST);

    // Timeout counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo_s;
    assign fire_s       = 1'b0;
    assign unused_tmo_s = ^TMO_LAST;
`endif

    // Zero-extended views of the status registers for read data.
    always_comb begin
        arrived_ext_s                 = 8'h00;
        arrived_ext_s[NHARTS-1:0]     = arrived_q;
        mask_ext_s                    = 32'h0000_0000;
        mask_ext_s[NHARTS-1:0]        = mask_q;
        unused_req_s                  = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            unused_req_s = unused_req_s ^ (^core_req_i[h]);
        end
    end

    // Per-hart FSMs, register decode and shared barrier state next-state.
    always_comb begin
        arrived_d = (release_s || fire_s) ? '0 : arrived_q;
        mask_d    = mask_q;
        gen_d     = release_s ? (gen_q + 8'd1) : gen_q;
        timeout_d = timeout_q;
        gnt_s     = '0;
        for (int h = 0; h < NHARTS; h++) begin
            state_d[h] = state_q[h];
            rdata_d[h] = rdata_q[h];
            case (state_q[h])
                ST_IDLE: begin
                    gnt_s[h] = core_req_i[h].req & ~rst_i;
                    if (gnt_s[h]) begin
                        state_d[h] = ST_RESP;
                        rdata_d[h] = 32'h0000_0000;
                        case (core_req_i[h].addr[3:2])
                            2'd0: begin
                                if (!core_req_i[h].we) begin
                                    if (mask_q[h]) begin
                                        arrived_d[h] = 1'b1;
                                        state_d[h]   = ST_WAIT;
                                    end else begin
                                        rdata_d[h] = {24'h000000, gen_q};
                                    end
                                end else begin
                                    rdata_d[h] = 32'h0000_0000;
                                end
                            end
                            2'd1: begin
                                if (!core_req_i[h].we) begin
                                    rdata_d[h] = {16'h0000, gen_q, arrived_ext_s};
                                end else begin
                                    timeout_d = 1'b0;
                                end
                            end
                            2'd2: begin
                                if (!core_req_i[h].we) begin
                                    rdata_d[h] = mask_ext_s;
                                end else if (core_req_i[h].be[0]) begin
                                    mask_d = core_req_i[h].wdata[NHARTS-1:0];
                                end else begin
                                    mask_d = mask_d;
                                end
                            end
                            default: begin
                                rdata_d[h] = 32'h0000_0000;
                            end
                        endcase
                    end else begin
                        state_d[h] = ST_IDLE;
                    end
                end
                ST_RESP: begin
                    state_d[h] = ST_IDLE;
                end
                ST_WAIT: begin
                    if (release_s || fire_s) begin
                        state_d[h] = ST_RESP;
                        rdata_d[h] = fire_s ? 32'hFFFF_FFFF : {24'h000000, gen_q};
                    end else begin
                        state_d[h] = ST_WAIT;
                    end
                end
                default: begin
                    state_d[h] = ST_IDLE;
                end
            endcase
        end
        // A forced release sets the sticky flag even if a clear is granted.
        if (fire_s) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_d;
        end
    end

    // State and register file update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arrived_q <= '0;
            mask_q    <= '1;
            gen_q     <= 8'h00;
            timeout_q <= 1'b0;
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h] <= ST_IDLE;
                rdata_q[h] <= 32'h0000_0000;
            end
        end else begin
            arrived_q <= arrived_d;
            mask_q    <= mask_d;
            gen_q     <= gen_d;
            timeout_q <= timeout_d;
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h] <= state_d[h];
                rdata_q[h] <= rdata_d[h];
            end
        end
    end

    // Response outputs: rdata only visible alongside rvalid.
    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            core_resp_o[h].gnt    = gnt_s[h];
            core_resp_o[h].rvalid = (state_q[h] == ST_RESP);
            if (state_q[h] == ST_RESP) begin
                core_resp_o[h].rdata = rdata_q[h];
            end else begin
                core_resp_o[h].rdata = 32'h0000_0000;
            end
        end
    end

endmodule
